draw_rect: RTL and testbench

- Parametrised rectangle rasteriser for the VGA path. Successor to the fixed 4x4 square drawer.
- Accepts an origin, a size, a colour and a fill/outline mode on a start handshake. Emits one pixel per clock (x, y, colour, plot) in row-major order.
- Reports busy/done so the graphics controller can sequence blocks, ball and clear operations without fixed delay counting.

---
 rtl/draw_rect.sv | 240 ++++++++++++++++++++++++
 tb/tb_draw_rect.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/draw_rect.sv
// ---------------------------------------------------------------------------
// draw_rect
// Parametrised rectangle rasteriser for the VGA path. A request (origin,
// size, colour, fill/outline mode) is accepted on start while idle; the block
// then emits one pixel per clock in row-major order (x fastest) and pulses
// done for one cycle after the last pixel, or one cycle after a zero-size
// request.
//
// Ports
//   clk        in   system clock, all logic on posedge
//   reset_n    in   synchronous active-low reset
//   start      in   draw request, sampled only while idle
//   xpos       in   [X_W]      origin x (left column)
//   ypos       in   [Y_W]      origin y (top row)
//   width      in   [SZ_W]     rectangle width in pixels
//   height     in   [SZ_W]     rectangle height in pixels
//   colourin   in   [COLOUR_W] pixel colour
//   outline    in   0 = filled, 1 = border only
//   busy       out  high while drawing
//   done       out  one-cycle pulse after the last pixel / zero-size request
//   xout       out  [X_W]      current pixel x (held while idle)
//   yout       out  [Y_W]      current pixel y (held while idle)
//   colourout  out  [COLOUR_W] current pixel colour (held while idle)
//   plot       out  pixel write strobe
// ---------------------------------------------------------------------------
module draw_rect #(
  parameter int unsigned X_W      = 12,
  parameter int unsigned Y_W      = 11,
  parameter int unsigned SZ_W     = 8,
  parameter int unsigned COLOUR_W = 3
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [X_W-1:0]      xpos,
  input  logic [Y_W-1:0]      ypos,
  input  logic [SZ_W-1:0]     width,
  input  logic [SZ_W-1:0]     height,
  input  logic [COLOUR_W-1:0] colourin,
  input  logic                outline,
  output logic                busy,
  output logic                done,
  output logic [X_W-1:0]      xout,
  output logic [Y_W-1:0]      yout,
  output logic [COLOUR_W-1:0] colourout,
  output logic                plot
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_DRAW = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Request registers, captured on the accepting edge
  logic [X_W-1:0]      r_x0;
  logic [Y_W-1:0]      r_y0;
  logic [SZ_W-1:0]     r_w;
  logic [SZ_W-1:0]     r_h;
  logic                r_outline;

  // Scan position relative to the origin
  logic [SZ_W-1:0]     r_cx;
  logic [SZ_W-1:0]     r_cy;

  // Registered outputs
  logic                r_busy;
  logic                r_done;
  logic                r_plot;
  logic [X_W-1:0]      r_xout;
  logic [Y_W-1:0]      r_yout;
  logic [COLOUR_W-1:0] r_colour;

  // Next-state values from the output process
  logic [X_W-1:0]      w_x0_nxt;
  logic [Y_W-1:0]      w_y0_nxt;
  logic [SZ_W-1:0]     w_w_nxt;
  logic [SZ_W-1:0]     w_h_nxt;
  logic                w_outline_nxt;
  logic [SZ_W-1:0]     w_cx_nxt;
  logic [SZ_W-1:0]     w_cy_nxt;
  logic                w_busy_nxt;
  logic                w_done_nxt;
  logic                w_plot_nxt;
  logic [X_W-1:0]      w_xout_nxt;
  logic [Y_W-1:0]      w_yout_nxt;
  logic [COLOUR_W-1:0] w_colour_nxt;

  // Scan decode
  logic                w_zero_req;
  logic                w_row_end;
  logic                w_last_row;
  logic                w_last;
  logic                w_skip_interior;

  assign w_zero_req = (width == '0) || (height == '0);
  assign w_row_end  = (r_cx == r_w - SZ_W'(1));
  assign w_last_row = (r_cy == r_h - SZ_W'(1));
  assign w_last     = w_row_end && w_last_row;

  // Middle rows of an outline jump straight from the left to the right edge
  assign w_skip_interior = r_outline && (r_w >= SZ_W'(2)) && (r_cx == '0) &&
                           (r_cy != '0) && !w_last_row;

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; a zero-size request never leaves IDLE
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start && !w_zero_req) begin
          w_state_nxt = S_DRAW;
        end
      end
      S_DRAW: begin
        if (w_last) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output / datapath next values; coordinates and colour hold by default
  always_comb begin
    w_plot_nxt    = 1'b0;
    w_busy_nxt    = 1'b0;
    w_done_nxt    = 1'b0;
    w_xout_nxt    = r_xout;
    w_yout_nxt    = r_yout;
    w_colour_nxt  = r_colour;
    w_cx_nxt      = r_cx;
    w_cy_nxt      = r_cy;
    w_x0_nxt      = r_x0;
    w_y0_nxt      = r_y0;
    w_w_nxt       = r_w;
    w_h_nxt       = r_h;
    w_outline_nxt = r_outline;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_x0_nxt      = xpos;
          w_y0_nxt      = ypos;
          w_w_nxt       = width;
          w_h_nxt       = height;
          w_outline_nxt = outline;
          if (w_zero_req) begin
            w_done_nxt = 1'b1;
          end else begin
            // First pixel is the origin, visible right after this edge
            w_plot_nxt   = 1'b1;
            w_busy_nxt   = 1'b1;
            w_xout_nxt   = xpos;
            w_yout_nxt   = ypos;
            w_colour_nxt = colourin;
            w_cx_nxt     = '0;
            w_cy_nxt     = '0;
          end
        end
      end
      S_DRAW: begin
        if (w_last) begin
          w_done_nxt = 1'b1;
          w_cx_nxt   = '0;
          w_cy_nxt   = '0;
        end else begin
          w_plot_nxt = 1'b1;
          w_busy_nxt = 1'b1;
          if (w_row_end) begin
            w_cx_nxt = '0;
            w_cy_nxt = r_cy + SZ_W'(1);
          end else if (w_skip_interior) begin
            w_cx_nxt = r_w - SZ_W'(1);
          end else begin
            w_cx_nxt = r_cx + SZ_W'(1);
          end
          // Sums wrap at the port width; no clipping
          w_xout_nxt = r_x0 + X_W'(w_cx_nxt);
          w_yout_nxt = r_y0 + Y_W'(w_cy_nxt);
        end
      end
      default: begin
        w_cx_nxt = '0;
        w_cy_nxt = '0;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_x0      <= '0;
      r_y0      <= '0;
      r_w       <= '0;
      r_h       <= '0;
      r_outline <= 1'b0;
      r_cx      <= '0;
      r_cy      <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_plot    <= 1'b0;
      r_xout    <= '0;
      r_yout    <= '0;
      r_colour  <= '0;
    end else begin
      r_x0      <= w_x0_nxt;
      r_y0      <= w_y0_nxt;
      r_w       <= w_w_nxt;
      r_h       <= w_h_nxt;
      r_outline <= w_outline_nxt;
      r_cx      <= w_cx_nxt;
      r_cy      <= w_cy_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_plot    <= w_plot_nxt;
      r_xout    <= w_xout_nxt;
      r_yout    <= w_yout_nxt;
      r_colour  <= w_colour_nxt;
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign plot      = r_plot;
  assign xout      = r_xout;
  assign yout      = r_yout;
  assign colourout = r_colour;

endmodule

// File: tb/tb_draw_rect.sv
// ---------------------------------------------------------------------------
// tb_draw_rect
// Self-checking bench for draw_rect. A transaction-level model turns each
// accepted request into the list of pixels it must produce (row-major,
// border-only when outlining) and predicts plot/busy/done/x/y/colour for
// every cycle; directed tests add hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_draw_rect;

  localparam int X_W  = 12;
  localparam int Y_W  = 11;
  localparam int SZ_W = 8;
  localparam int C_W  = 3;

  logic            clk      = 1'b0;
  logic            reset_n  = 1'b0;
  logic            start    = 1'b0;
  logic [X_W-1:0]  xpos     = '0;
  logic [Y_W-1:0]  ypos     = '0;
  logic [SZ_W-1:0] width    = '0;
  logic [SZ_W-1:0] height   = '0;
  logic [C_W-1:0]  colourin = '0;
  logic            outline  = 1'b0;
  logic            busy;
  logic            done;
  logic [X_W-1:0]  xout;
  logic [Y_W-1:0]  yout;
  logic [C_W-1:0]  colourout;
  logic            plot;

  draw_rect #(.X_W(X_W), .Y_W(Y_W), .SZ_W(SZ_W), .COLOUR_W(C_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .xpos(xpos), .ypos(ypos), .width(width), .height(height),
    .colourin(colourin), .outline(outline),
    .busy(busy), .done(done), .xout(xout), .yout(yout),
    .colourout(colourout), .plot(plot)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- transaction model + per-cycle compare ----------------
  typedef struct {
    int x;
    int y;
  } pix_t;

  pix_t q[$];
  pix_t mp;
  bit   m_busy  = 1'b0;
  bit   started = 1'b0;
  int   e_plot, e_busy, e_done, e_x, e_y, e_c;

  always @(negedge clk) begin
    if (started) begin
      n_vec++;
      if (plot !== 1'(e_plot) || busy !== 1'(e_busy) || done !== 1'(e_done) ||
          xout !== X_W'(e_x) || yout !== Y_W'(e_y) || colourout !== C_W'(e_c)) begin
        n_err++;
        $display("FAIL cycle@%0t: got plot=%b busy=%b done=%b x=%0d y=%0d c=%0d, expected plot=%0d busy=%0d done=%0d x=%0d y=%0d c=%0d",
                 $time, plot, busy, done, xout, yout, colourout,
                 e_plot, e_busy, e_done, e_x, e_y, e_c);
      end
    end
    // Predict outputs after the coming posedge from inputs now stable
    if (!reset_n) begin
      q.delete();
      m_busy = 1'b0;
      e_plot = 0; e_busy = 0; e_done = 0; e_x = 0; e_y = 0; e_c = 0;
    end else if (m_busy) begin
      e_done = 0;
      if (q.size() > 0) begin
        mp  = q.pop_front();
        e_x = mp.x;
        e_y = mp.y;
      end else begin
        m_busy = 1'b0;
        e_plot = 0; e_busy = 0; e_done = 1;
      end
    end else begin
      e_plot = 0; e_busy = 0; e_done = 0;
      if (start) begin
        if (width == '0 || height == '0) begin
          e_done = 1;
        end else begin
          for (int yy = 0; yy < int'(height); yy++) begin
            for (int xx = 0; xx < int'(width); xx++) begin
              if (!outline || yy == 0 || yy == int'(height) - 1 ||
                  xx == 0 || xx == int'(width) - 1) begin
                q.push_back('{x: (int'(xpos) + xx) % (1 << X_W),
                              y: (int'(ypos) + yy) % (1 << Y_W)});
              end
            end
          end
          mp     = q.pop_front();
          e_x    = mp.x;
          e_y    = mp.y;
          e_c    = int'(colourin);
          e_plot = 1; e_busy = 1;
          m_busy = 1'b1;
        end
      end
    end
    started = 1'b1;
  end

  // ---------------- directed stimulus ----------------
  task automatic run_rect(input int x0, input int y0, input int w, input int h,
                          input int c, input bit ol,
                          output int cnt, output int fx, output int fy,
                          output int lx, output int ly, output int cyc);
    bit got;
    @(posedge clk); #1;
    xpos = X_W'(x0); ypos = Y_W'(y0); width = SZ_W'(w); height = SZ_W'(h);
    colourin = C_W'(c); outline = ol; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cnt = 0; cyc = 0; fx = -1; fy = -1; lx = -1; ly = -1; got = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      cyc++;
      if (plot === 1'b1) begin
        if (cnt == 0) begin
          fx = int'(xout); fy = int'(yout);
        end
        lx = int'(xout); ly = int'(yout);
        cnt++;
      end
      if (done === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    chk("done_seen", int'(got), 1);
    if (got) chk("busy_low_in_done", int'(busy), 0);
  endtask

  int cnt, fx, fy, lx, ly, cyc, ndone;

  initial begin
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("reset_plot", int'(plot), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_xout", int'(xout), 0);

    // Filled 4x4 at (148,18), colour 100
    run_rect(148, 18, 4, 4, 4, 1'b0, cnt, fx, fy, lx, ly, cyc);
    chk("fill4_count", cnt, 16);
    chk("fill4_first_x", fx, 148);
    chk("fill4_first_y", fy, 18);
    chk("fill4_last_x", lx, 151);
    chk("fill4_last_y", ly, 21);
    chk("fill4_cycles", cyc, 17);
    chk("fill4_colour", int'(colourout), 4);

    // Outline 4x3 at (0,0)
    run_rect(0, 0, 4, 3, 1, 1'b1, cnt, fx, fy, lx, ly, cyc);
    chk("out43_count", cnt, 10);
    chk("out43_last_x", lx, 3);
    chk("out43_last_y", ly, 2);
    chk("out43_cycles", cyc, 11);

    // Zero size
    run_rect(9, 9, 0, 5, 2, 1'b0, cnt, fx, fy, lx, ly, cyc);
    chk("zero_count", cnt, 0);
    chk("zero_done_latency", cyc, 1);

    // Degenerate outline 1x5 at (2,2)
    run_rect(2, 2, 1, 5, 6, 1'b1, cnt, fx, fy, lx, ly, cyc);
    chk("deg_count", cnt, 5);
    chk("deg_first_y", fy, 2);
    chk("deg_last_x", lx, 2);
    chk("deg_last_y", ly, 6);

    // Filled 255x1 at (100,9)
    run_rect(100, 9, 255, 1, 7, 1'b0, cnt, fx, fy, lx, ly, cyc);
    chk("wide_count", cnt, 255);
    chk("wide_last_x", lx, 354);
    chk("wide_last_y", ly, 9);

    // Wrap 2x1 at (4095,7), start held during busy, back-to-back 1x1 at (5,5)
    @(posedge clk); #1;
    xpos = 12'd4095; ypos = 11'd7; width = 8'd2; height = 8'd1;
    colourin = 3'd5; outline = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    xpos = 12'd999; ypos = 11'd99; width = 8'd9; height = 8'd9; colourin = 3'd1;
    @(negedge clk);
    chk("wrap_p0_x", int'(xout), 4095);
    chk("wrap_p0_y", int'(yout), 7);
    @(posedge clk); #1;
    @(negedge clk);
    chk("wrap_p1_x", int'(xout), 0);
    chk("wrap_p1_plot", int'(plot), 1);
    @(posedge clk); #1;
    xpos = 12'd5; ypos = 11'd5; width = 8'd1; height = 8'd1; colourin = 3'd2;
    @(negedge clk);
    chk("wrap_done", int'(done), 1);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("b2b_plot", int'(plot), 1);
    chk("b2b_x", int'(xout), 5);
    chk("b2b_y", int'(yout), 5);
    chk("b2b_colour", int'(colourout), 2);
    @(negedge clk);
    chk("b2b_done", int'(done), 1);

    // Reset mid-draw: 8x8 at (10,20), reset during the 5th pixel
    @(posedge clk); #1;
    xpos = 12'd10; ypos = 11'd20; width = 8'd8; height = 8'd8;
    colourin = 3'd3; outline = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset_n = 1'b0;
    @(negedge clk);
    chk("rst_5th_x", int'(xout), 14);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_plot", int'(plot), 0);
    chk("rst_busy", int'(busy), 0);
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    chk("rst_no_done", ndone, 0);
    run_rect(1, 1, 2, 2, 4, 1'b0, cnt, fx, fy, lx, ly, cyc);
    chk("post_rst_count", cnt, 4);
    chk("post_rst_last_x", lx, 2);
    chk("post_rst_last_y", ly, 2);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
